fsm_trace: RTL and testbench

Downstream state-trace monitor for the 5-state enable-gated FSM. It samples the FSM's 3-bit state output every clock and detects state transitions. Each transition becomes a record of from state, to state and dwell cycles, buffered in a small FIFO and drained over a valid/ready stream. It also keeps saturating transition and drop counters and a sticky illegal-state flag for debug readout.

---
 rtl/fsm_trace_pkg.sv | 14 +
 rtl/fsm_trace_fifo.sv | 34 +++
 rtl/fsm_trace.sv | 58 +++++
 tb/tb_fsm_trace.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fsm_trace_pkg.sv
// fsm_trace_pkg: shared constants and trace record type for the FSM state-trace monitor
package fsm_trace_pkg;
  localparam int SW_DEF = 3;
  localparam int NSTATES_DEF = 5;
  localparam int DW_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int TCW = 16;
  localparam int DCW = 8;
  typedef struct packed {
    logic [SW_DEF-1:0] from;
    logic [SW_DEF-1:0] to;
    logic [DW_DEF-1:0] dwell;
  } trace_rec_t;
endpackage

// File: rtl/fsm_trace_fifo.sv
// fsm_trace_fifo: synchronous FIFO with wrap-bit pointers; a push on full is accepted when a pop frees the slot
module fsm_trace_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clock)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/fsm_trace.sv
// fsm_trace: records FSM state transitions {from, to, dwell} into a FIFO with saturating debug counters
module fsm_trace
  import fsm_trace_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int NSTATES = NSTATES_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic [SW-1:0]  state,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_from,
  output logic [SW-1:0]  out_to,
  output logic [DW-1:0]  out_dwell,
  output logic [TCW-1:0] trans_count,
  output logic [DCW-1:0] drop_count,
  output logic           illegal
);
  localparam int RW = 2 * SW + DW;
  logic [SW-1:0] prev;
  logic [DW-1:0] cnt;
  logic [RW-1:0] head;
  logic trans, pop, full, empty, bad;
  assign trans = state != prev;
  assign pop = out_valid & out_ready;
  assign bad = 32'(state) >= NSTATES;
  assign out_valid = ~empty;
  // head is masked so an empty FIFO shows all-zero fields
  assign {out_from, out_to, out_dwell} = empty ? '0 : head;
  fsm_trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(trans),
    .pop(pop),
    .wdata({prev, state, cnt}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prev <= '0;
      cnt <= '0;
      trans_count <= '0;
      drop_count <= '0;
      illegal <= 1'b0;
    end else begin
      prev <= state;
      cnt <= trans ? DW'(1) : (&cnt ? cnt : cnt + 1'b1);
      trans_count <= clear ? '0 : (trans & ~&trans_count) ? trans_count + 1'b1 : trans_count;
      drop_count <= clear ? '0 : (trans & full & ~pop & ~&drop_count) ? drop_count + 1'b1 : drop_count;
      illegal <= ~clear & (illegal | bad);
    end
endmodule

// File: tb/tb_fsm_trace.sv
// tb_fsm_trace: directed scoreboard bench for fsm_trace
module tb_fsm_trace;
  import fsm_trace_pkg::*;
  logic clock, reset, clear, out_valid, out_ready, illegal;
  logic [2:0] state, out_from, out_to;
  logic [7:0] out_dwell, drop_count;
  logic [15:0] trans_count;
  int checks = 0;
  int errors = 0;
  trace_rec_t q[$];
  logic [2:0] m_prev;
  logic [7:0] m_cnt, m_dc;
  logic [15:0] m_tc;
  logic m_ill;

  fsm_trace dut (
    .clock(clock), .reset(reset), .clear(clear), .state(state),
    .out_valid(out_valid), .out_ready(out_ready), .out_from(out_from),
    .out_to(out_to), .out_dwell(out_dwell), .trans_count(trans_count),
    .drop_count(drop_count), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("head", {out_from, out_to, out_dwell}, 32'(q[0]));
    else chk("head_zero", {out_from, out_to, out_dwell}, 32'd0);
    chk("trans_count", trans_count, m_tc);
    chk("drop_count", drop_count, m_dc);
    chk("illegal", illegal, m_ill);
  endtask

  task automatic model_edge();
    if (out_ready && q.size() != 0) void'(q.pop_front());
    if (state != m_prev) begin
      if (q.size() < 4) q.push_back('{from: m_prev, to: state, dwell: m_cnt});
      else if (m_dc != 8'hFF) m_dc++;
      if (m_tc != 16'hFFFF) m_tc++;
      m_prev = state;
      m_cnt = 8'd1;
    end else if (m_cnt != 8'hFF) m_cnt++;
    if (state >= 3'd5) m_ill = 1'b1;
    if (clear) begin
      m_tc = '0;
      m_dc = '0;
      m_ill = 1'b0;
    end
  endtask

  task automatic step(input logic [2:0] s, input logic rdy, input logic clr);
    state = s;
    out_ready = rdy;
    clear = clr;
    @(negedge clock);
    check_outputs();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    q.delete();
    m_prev = '0;
    m_cnt = '0;
    m_tc = '0;
    m_dc = '0;
    m_ill = 1'b0;
    check_outputs();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    state = '0;
    out_ready = 1'b0;
    do_reset();
    repeat (3) step(3'd0, 1'b1, 1'b0);
    step(3'd1, 1'b1, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_rec", {out_from, out_to, out_dwell}, {3'd0, 3'd1, 8'd3});
    chk("t1_tc", trans_count, 1);
    step(3'd1, 1'b1, 1'b0);
    chk("t1_one_cycle", out_valid, 0);
    do_reset();
    for (int s = 0; s < 5; s++) repeat (2) step(3'(s), 1'b0, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    chk("walk_drop", drop_count, 1);
    chk("walk_tc", trans_count, 5);
    chk("walk_head", {out_from, out_to, out_dwell}, {3'd0, 3'd1, 8'd2});
    step(3'd1, 1'b1, 1'b0);
    chk("fullpop_drop", drop_count, 1);
    chk("fullpop_head", {out_from, out_to, out_dwell}, {3'd1, 3'd2, 8'd2});
    repeat (4) step(3'd1, 1'b1, 1'b0);
    chk("drained", out_valid, 0);
    repeat (300) step(3'd2, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    chk("sat_dwell", {out_from, out_to, out_dwell}, {3'd2, 3'd3, 8'd255});
    step(3'd6, 1'b0, 1'b0);
    chk("illegal_set", illegal, 1);
    step(3'd6, 1'b0, 1'b1);
    chk("clear_ill", illegal, 0);
    chk("clear_tc", trans_count, 0);
    chk("clear_keep", {out_from, out_to, out_dwell}, {3'd2, 3'd3, 8'd255});
    step(3'd0, 1'b0, 1'b0);
    chk("three_buf", 32'(q.size()), 3);
    do_reset();
    chk("async_valid", out_valid, 0);
    repeat (2) step(3'd0, 1'b1, 1'b0);
    step(3'd2, 1'b1, 1'b0);
    chk("post_reset_rec", {out_from, out_to, out_dwell}, {3'd0, 3'd2, 8'd2});
    step(3'd2, 1'b1, 1'b0);
    @(negedge clock);
    check_outputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
